// File: rtl/arbitro_barramento_pkg.sv
// rtl/arbitro_barramento_pkg.sv - shared types and constants for the Barramento arbiter
package pacote_barramento;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        TRANSFERE = 2'd1,
        LIBERA    = 2'd2
    } estado_t;

    localparam logic [1:0] CTRL_NADA     = 2'b00;
    localparam logic [1:0] CTRL_LER      = 2'b01;
    localparam logic [1:0] CTRL_ESCREVER = 2'b10;

    localparam int N_PORTAS           = 6;
    localparam int LARGURA_BARRAMENTO = 16;

endpackage

// File: rtl/arbitro_barramento_seletor_rr.sv
// rtl/arbitro_barramento_seletor_rr.sv - combinational round-robin search starting after ptr
module seletor_rr
    import pacote_barramento::*;
(
    input  logic [2:0]          ptr,
    input  logic [N_PORTAS-1:0] valido,
    output logic                achou,
    output logic [2:0]          indice
);

    logic [2:0] cand;

    // The port at ptr itself is visited last, giving it the lowest priority.
    always_comb begin
        achou  = 1'b0;
        indice = '0;
        cand   = '0;
        for (int k = 1; k <= N_PORTAS; k++) begin
            cand = 3'((int'(ptr) + k) % N_PORTAS);
            if (!achou && valido[cand]) begin
                achou  = 1'b1;
                indice = cand;
            end
        end
    end

endmodule

// File: rtl/arbitro_barramento.sv
// rtl/arbitro_barramento.sv - round-robin arbiter driving the Barramento ctrl_* inputs
// Optional transfer timeout enabled with `define ARBITRO_TIMEOUT_EN.
module arbitro_barramento #(
    parameter int N_PORTAS       = 6,
    parameter int TIMEOUT_CICLOS = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_PORTAS-1:0]     req,
    input  logic [3*N_PORTAS-1:0]   dst,
    output logic [1:0]              ctrl_0,
    output logic [1:0]              ctrl_1,
    output logic [1:0]              ctrl_2,
    output logic [1:0]              ctrl_3,
    output logic [1:0]              ctrl_4,
    output logic [1:0]              ctrl_5,
    output logic [N_PORTAS-1:0]     grant,
    output logic                    ocupado,
    output logic [N_PORTAS-1:0]     erro,
    output logic                    timeout
);

    import pacote_barramento::estado_t;
    import pacote_barramento::OCIOSO;
    import pacote_barramento::TRANSFERE;
    import pacote_barramento::LIBERA;
    import pacote_barramento::CTRL_NADA;
    import pacote_barramento::CTRL_LER;
    import pacote_barramento::CTRL_ESCREVER;

    localparam logic [N_PORTAS-1:0] UM = 1;

    estado_t estado, estado_prox;
    logic [2:0] src, src_prox;
    logic [2:0] dst_l, dst_l_prox;
    logic [2:0] ptr, ptr_prox;

    logic [2:0]          dst_porta [N_PORTAS];
    logic [N_PORTAS-1:0] valido;
    logic [N_PORTAS-1:0] invalido;
    logic [N_PORTAS-1:0] mascara;
    logic                achou;
    logic [2:0]          indice;

    logic [N_PORTAS-1:0][1:0] ctrl_r, ctrl_prox;
    logic [N_PORTAS-1:0]      grant_prox;
    logic [N_PORTAS-1:0]      erro_prox;
    logic                     ocupado_prox;
    logic                     timeout_prox;

`ifdef ARBITRO_TIMEOUT_EN
    localparam logic [7:0] LIMITE = 8'(TIMEOUT_CICLOS);

    logic [7:0] cont;

    // A timed-out port stays masked until its req has been seen low once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cont    <= '0;
            mascara <= '0;
        end else begin
            cont    <= (estado == TRANSFERE) ? cont + 8'd1 : 8'd0;
            mascara <= (mascara & req) | (timeout_prox ? (UM << src) : '0);
        end
    end
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CICLOS);
    assign mascara        = '0;
`endif

    always_comb begin
        for (int i = 0; i < N_PORTAS; i++) begin
            dst_porta[i] = dst[3*i +: 3];
            invalido[i]  = req[i] && ((dst_porta[i] >= 3'(N_PORTAS)) || (dst_porta[i] == 3'(i)));
            valido[i]    = req[i] && !invalido[i] && !mascara[i];
        end
    end

    seletor_rr u_seletor (
        .ptr    (ptr),
        .valido (valido),
        .achou  (achou),
        .indice (indice)
    );

    always_comb begin
        estado_prox  = estado;
        src_prox     = src;
        dst_l_prox   = dst_l;
        ptr_prox     = ptr;
        erro_prox    = '0;
        timeout_prox = 1'b0;
        case (estado)
            TRANSFERE: begin
                if (!req[src]) begin
                    estado_prox = LIBERA;
                end
`ifdef ARBITRO_TIMEOUT_EN
                else if (cont == LIMITE - 8'd1) begin
                    estado_prox  = LIBERA;
                    timeout_prox = 1'b1;
                end
`endif
            end
            default: begin
                erro_prox = invalido;
                if (achou) begin
                    estado_prox = TRANSFERE;
                    src_prox    = indice;
                    dst_l_prox  = dst_porta[indice];
                    ptr_prox    = indice;
                end else begin
                    estado_prox = OCIOSO;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_comb begin
        ctrl_prox    = '0;
        grant_prox   = '0;
        ocupado_prox = 1'b0;
        for (int i = 0; i < N_PORTAS; i++) begin
            ctrl_prox[i] = CTRL_NADA;
        end
        if (estado_prox == TRANSFERE) begin
            ctrl_prox[src_prox]   = CTRL_ESCREVER;
            ctrl_prox[dst_l_prox] = CTRL_LER;
            grant_prox            = UM << src_prox;
            ocupado_prox          = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado  <= OCIOSO;
            src     <= '0;
            dst_l   <= '0;
            ptr     <= 3'(N_PORTAS - 1);
            ctrl_r  <= '0;
            grant   <= '0;
            ocupado <= 1'b0;
            erro    <= '0;
            timeout <= 1'b0;
        end else begin
            estado  <= estado_prox;
            src     <= src_prox;
            dst_l   <= dst_l_prox;
            ptr     <= ptr_prox;
            ctrl_r  <= ctrl_prox;
            grant   <= grant_prox;
            ocupado <= ocupado_prox;
            erro    <= erro_prox;
            timeout <= timeout_prox;
        end
    end

    assign ctrl_0 = ctrl_r[0];
    assign ctrl_1 = ctrl_r[1];
    assign ctrl_2 = ctrl_r[2];
    assign ctrl_3 = ctrl_r[3];
    assign ctrl_4 = ctrl_r[4];
    assign ctrl_5 = ctrl_r[5];

endmodule

// File: tb/tb_arbitro_barramento.sv
// tb/tb_arbitro_barramento.sv - table-driven self-checking bench for arbitro_barramento
module tb_arbitro_barramento;

`ifdef ARBITRO_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`else
    localparam int TB_TIMEOUT = 16;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  req;
    logic [17:0] dst;
    logic [1:0]  ctrl_0, ctrl_1, ctrl_2, ctrl_3, ctrl_4, ctrl_5;
    logic [5:0]  grant;
    logic        ocupado;
    logic [5:0]  erro;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst_n;
        logic [5:0]  req;
        logic [17:0] dst;
        logic [11:0] ctrl;
        logic [5:0]  grant;
        logic [5:0]  erro;
        logic        tmo;
    } vetor_t;

    vetor_t tab[$];

    arbitro_barramento #(.N_PORTAS(6), .TIMEOUT_CICLOS(TB_TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .dst     (dst),
        .ctrl_0  (ctrl_0),
        .ctrl_1  (ctrl_1),
        .ctrl_2  (ctrl_2),
        .ctrl_3  (ctrl_3),
        .ctrl_4  (ctrl_4),
        .ctrl_5  (ctrl_5),
        .grant   (grant),
        .ocupado (ocupado),
        .erro    (erro),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] mk(input int d0, d1, d2, d3, d4, d5);
        return {3'(d5), 3'(d4), 3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    task automatic add(input logic r, input logic [5:0] q, input logic [17:0] d,
                       input logic [11:0] c, input logic [5:0] g, input logic [5:0] e,
                       input logic t);
        vetor_t v;
        v.rst_n = r; v.req = q; v.dst = d; v.ctrl = c; v.grant = g; v.erro = e; v.tmo = t;
        tab.push_back(v);
    endtask

    task automatic chk(input string nome, input int idx, input logic [11:0] got,
                       input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %h expected %h", nome, idx, got, exp);
        end
    endtask

    task automatic ciclo(input logic r, input logic [5:0] q, input logic [17:0] d);
        rst_n = r;
        req   = q;
        dst   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic confere(input int idx, input logic [11:0] c, input logic [5:0] g,
                           input logic [5:0] e, input logic t);
        chk("ctrl", idx, {ctrl_5, ctrl_4, ctrl_3, ctrl_2, ctrl_1, ctrl_0}, c);
        chk("grant", idx, 12'(grant), 12'(g));
        chk("ocupado", idx, 12'(ocupado), 12'(g != 6'd0));
        chk("erro", idx, 12'(erro), 12'(e));
        chk("timeout", idx, 12'(timeout), 12'(t));
    endtask

    initial begin
        logic [17:0] d_ok, d_s, d_i1, d_i2, d_c, d_m2, d_z;
        d_ok = mk(1, 2, 3, 4, 5, 0);
        d_s  = mk(1, 2, 4, 4, 5, 0);
        d_i1 = mk(1, 2, 3, 3, 5, 0);
        d_i2 = mk(1, 2, 3, 7, 5, 0);
        d_c  = mk(1, 3, 3, 4, 5, 0);
        d_m2 = mk(2, 2, 3, 4, 5, 0);
        d_z  = mk(1, 0, 3, 4, 5, 0);

        // reset, then single transfer 2->4 held for three cycles
        add(0, 6'b000000, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
        for (int i = 0; i < 3; i++) add(1, 6'b000100, d_s, 12'h120, 6'b000100, 6'b000000, 0);
        add(1, 6'b000000, d_s, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b000000, d_s, 12'h000, 6'b000000, 6'b000000, 0);

        // round-robin from reset: 0,1,2,3,4,5 then 0 again with idle cycles between
        add(0, 6'b000000, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b111111, d_ok, 12'h006, 6'b000001, 6'b000000, 0);
        add(1, 6'b111110, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b111110, d_ok, 12'h018, 6'b000010, 6'b000000, 0);
        add(1, 6'b111100, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b111100, d_ok, 12'h060, 6'b000100, 6'b000000, 0);
        add(1, 6'b111000, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b111000, d_ok, 12'h180, 6'b001000, 6'b000000, 0);
        add(1, 6'b110000, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b110000, d_ok, 12'h600, 6'b010000, 6'b000000, 0);
        add(1, 6'b100000, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b100000, d_ok, 12'h801, 6'b100000, 6'b000000, 0);
        add(1, 6'b011111, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b011111, d_ok, 12'h006, 6'b000001, 6'b000000, 0);
        add(1, 6'b000000, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b000000, d_ok, 12'h000, 6'b000000, 6'b000000, 0);

        // invalid destination: self, then out of range; erro only when evaluated
        add(1, 6'b001000, d_i1, 12'h000, 6'b000000, 6'b001000, 0);
        add(1, 6'b001000, d_i1, 12'h000, 6'b000000, 6'b001000, 0);
        add(1, 6'b001000, d_i2, 12'h000, 6'b000000, 6'b001000, 0);
        add(1, 6'b000000, d_i2, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b001001, d_i2, 12'h006, 6'b000001, 6'b001000, 0);
        add(1, 6'b001001, d_i2, 12'h006, 6'b000001, 6'b000000, 0);
        add(1, 6'b001000, d_i2, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b001000, d_i2, 12'h000, 6'b000000, 6'b001000, 0);
        add(1, 6'b000000, d_ok, 12'h000, 6'b000000, 6'b000000, 0);

        // two sources to the same destination are serialized
        add(1, 6'b000110, d_c, 12'h048, 6'b000010, 6'b000000, 0);
        add(1, 6'b000100, d_c, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b000100, d_c, 12'h060, 6'b000100, 6'b000000, 0);
        add(1, 6'b000000, d_c, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b000000, d_c, 12'h000, 6'b000000, 6'b000000, 0);

        // dst change during transfer 0->1 is ignored
        add(1, 6'b000001, d_ok, 12'h006, 6'b000001, 6'b000000, 0);
        add(1, 6'b000001, d_m2, 12'h006, 6'b000001, 6'b000000, 0);
        add(1, 6'b000001, d_m2, 12'h006, 6'b000001, 6'b000000, 0);
        add(1, 6'b000000, d_m2, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b000000, d_m2, 12'h000, 6'b000000, 6'b000000, 0);

        // reset during 1->0; afterwards port 0 beats port 2
        add(1, 6'b000010, d_z, 12'h009, 6'b000010, 6'b000000, 0);
        add(1, 6'b000010, d_z, 12'h009, 6'b000010, 6'b000000, 0);
        add(0, 6'b000101, d_z, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b000101, d_z, 12'h006, 6'b000001, 6'b000000, 0);
        add(1, 6'b000000, d_z, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b000000, d_z, 12'h000, 6'b000000, 6'b000000, 0);

`ifdef ARBITRO_TIMEOUT_EN
        // port 5 held forever: 4 cycles, timeout pulse, port 0 served, 5 masked
        add(1, 6'b100000, d_ok, 12'h801, 6'b100000, 6'b000000, 0);
        for (int i = 0; i < 3; i++) add(1, 6'b100001, d_ok, 12'h801, 6'b100000, 6'b000000, 0);
        add(1, 6'b100001, d_ok, 12'h000, 6'b000000, 6'b000000, 1);
        add(1, 6'b100001, d_ok, 12'h006, 6'b000001, 6'b000000, 0);
        for (int i = 0; i < 3; i++) add(1, 6'b100000, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b000000, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b100000, d_ok, 12'h801, 6'b100000, 6'b000000, 0);
        add(1, 6'b000000, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
        add(1, 6'b000000, d_ok, 12'h000, 6'b000000, 6'b000000, 0);
`endif

        rst_n = 1'b0;
        req   = '0;
        dst   = '0;
        @(negedge clk);
        foreach (tab[i]) begin
            ciclo(tab[i].rst_n, tab[i].req, tab[i].dst);
            confere(i, tab[i].ctrl, tab[i].grant, tab[i].erro, tab[i].tmo);
        end

`ifndef ARBITRO_TIMEOUT_EN
        // without the timeout a transfer 4->5 lasts as long as req is held
        for (int i = 0; i < 20; i++) begin
            ciclo(1'b1, 6'b010000, d_ok);
            confere(1000 + i, 12'h600, 6'b010000, 6'b000000, 1'b0);
        end
        ciclo(1'b1, 6'b000000, d_ok);
        confere(1020, 12'h000, 6'b000000, 6'b000000, 1'b0);
        ciclo(1'b1, 6'b000000, d_ok);
        confere(1021, 12'h000, 6'b000000, 6'b000000, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/arbitro_barramento.md
# arbitro_barramento

Synchronous round-robin arbiter that generates the per-port `ctrl_0`..`ctrl_5` signals consumed by the 6-port shared bus `Barramento`. Each port raises a request naming a destination port. The arbiter grants one transfer at a time: the source gets write and the destination gets read. It inserts one idle turnaround cycle between owners so no two ports ever drive `io_*` together. It sits directly upstream of `Barramento`, with its `ctrl_*` outputs wired straight to the bus control inputs.

## Interface
- `N_PORTAS`, 6: number of bus ports. It is fixed by `Barramento`; other values are unsupported.
- `TIMEOUT_CICLOS`, 16: maximum length of a transfer in cycles. Used only with `ARBITRO_TIMEOUT_EN`. Legal range is 1..255.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous reset, active-low.
- `req` in 6: `req[i]` = port i requests the bus. It must be held for the whole transfer.
- `dst` in 18: packed destination index per port; `dst[3i+2:3i]` belongs to port i.
- `ctrl_0`..`ctrl_5` out 2 each: bus control per port. Bit 0 = read (ler), bit 1 = write (escrever), registered.
- `grant` out 6: one-hot current owner (source), registered.
- `ocupado` out 1: a transfer is in progress, registered.
- `erro` out 6: one-cycle pulse per port when its request was rejected.
- `timeout` out 1: one-cycle pulse when a transfer is forcibly ended.

## Operation
- **States:**
  - OCIOSO: no owner.
  - TRANSFERE: owner `src` and latched `dst_l` active.
  - LIBERA: one turnaround cycle with all `ctrl_*` = 00.
- **Request validity:** a request is valid when `req[i]`=1, `dst_i` < 6, and `dst_i` ≠ i.
  - If `req[i]`=1 with an invalid `dst_i`, the arbiter pulses `erro[i]` for one cycle.
  - The pulse repeats every cycle the request is evaluated, which is only when the arbiter is in OCIOSO or LIBERA.
- **Arbitration** happens in OCIOSO and LIBERA.
  - Search starts at `ptr+1` and wraps mod 6; the first valid request wins.
  - On a win: `src`←i, `dst_l`←`dst_i`, `ptr`←i, go to TRANSFERE.
  - If no valid request is found, go to (or stay in) OCIOSO.
- **Outputs in TRANSFERE:**
  - `ctrl_src`=10 and `ctrl_dst_l`=01; all other `ctrl_*`=00.
  - `grant`=one-hot(`src`) and `ocupado`=1.
- **Latching:** `dst` changes during a transfer are ignored; `dst_l` is latched at grant.
- **End of transfer:** when `req[src]` is sampled 0 in TRANSFERE, go to LIBERA. In LIBERA, all `ctrl_*`=00, `grant`=0 and `ocupado`=0.
- **Simultaneous requests:** when several requests arrive together, the round-robin order decides. A port that just released has the lowest priority at the next arbitration.
- **Contention:** two ports targeting the same destination, or a destination that is itself requesting, are not errors. They are serialized by arbitration.
- **Reset:** when `rst_n`=0 at an edge:
  - state←OCIOSO and `ptr`←5, so port 0 has first priority.
  - All `ctrl_*`=00, `grant`=0, `ocupado`=0, `erro`=0 and `timeout`=0.
  - This also applies mid-transfer: the bus is released at the next edge with no LIBERA cycle.

## Timing
- **Grant latency:** a request sampled at edge t in OCIOSO gives `ctrl_*`/`grant` valid after edge t, i.e. during cycle t+1.
- **Release:** `req[src]` sampled low at edge t gives `ctrl_*`=00 during cycle t+1 (LIBERA).
- **Back-to-back:** if a valid request is pending at edge t+1, the next owner's `ctrl_*` appear in cycle t+2. This guarantees exactly one idle cycle between owners.
- **Transfer length:** a transfer lasts as many cycles as `req[src]` stays high after the grant edge, with a minimum of 1.
- **`erro` timing:** `erro` pulses in the cycle after the invalid request is sampled.

## Configuration
- **`ARBITRO_TIMEOUT_EN` defined:**
  - An 8-bit counter clears at grant and increments each TRANSFERE cycle.
  - When it reaches `TIMEOUT_CICLOS` with `req[src]` still high, the arbiter goes to LIBERA and pulses `timeout` in the LIBERA cycle.
  - The timed-out port is masked from arbitration until its `req` is sampled 0 once.
- **`ARBITRO_TIMEOUT_EN` undefined:**
  - No counter and no mask.
  - `timeout` is tied to 0 and transfers are unbounded.

## Structure
- **Package `pacote_barramento`:**
  - State type (OCIOSO, TRANSFERE, LIBERA).
  - Constants `CTRL_NADA`=2'b00, `CTRL_LER`=2'b01, `CTRL_ESCREVER`=2'b10.
  - `N_PORTAS`=6 and `LARGURA_BARRAMENTO`=16 (shared with `Barramento`).
- **Sub-module `seletor_rr`:** combinational round-robin priority search. It takes `ptr` and a 6-bit valid mask and returns a found flag plus a 3-bit index.
- **Top level:** holds the FSM, `ptr`, the latches, the counter and the output registers.

## Test plan
- **Single transfer:** after reset, `req[2]`=1 with `dst_2`=4 for 3 cycles. Expect `ctrl_2`=10, `ctrl_4`=01 and `grant`=000100 for 3 cycles, then one LIBERA cycle with all `ctrl_*`=00.
- **Round-robin:** `req` = 6'b111111 with valid destinations, each requester dropping after 1 cycle. Expect grant order 0,1,2,3,4,5,0, with an idle cycle between each.
- **Invalid destination:** `req[3]`=1 with `dst_3`=3, then `dst_3`=7. Expect an `erro[3]` pulse each evaluated cycle and `ctrl_*` staying 00.
- **Reset mid-transfer:** port 1→0 active; assert `rst_n`=0 for 1 cycle. Expect all outputs 0 at the next edge; port 0 wins the first grant after reset if requesting.
- **Timeout (macro on, `TIMEOUT_CICLOS`=4):** port 5 holds `req` indefinitely. Expect 4 TRANSFERE cycles, a `timeout` pulse, and port 5 not regranted while `req[5]` stays high. Port 0, requesting meanwhile, is granted.
- **Mid-transfer `dst` change:** during port 0→1, change `dst_0` to 2. Expect `ctrl_1` to remain 01 and `ctrl_2` to remain 00.
